// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select and ID-stage hazard detection for an in-order pipeline
// with single-cycle load-use bubbles and a scoreboard for long-latency writebacks.
module fwd_hazard_unit #(
  parameter int AW      = 5,
  parameter int NUM_SRC = 2,
  parameter int MAX_OUT = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   id_valid_i,
  input  logic [NUM_SRC*AW-1:0]  id_src_i,
  input  logic [NUM_SRC-1:0]     id_src_use_i,
  input  logic [AW-1:0]          id_rd_i,
  input  logic                   id_we_i,
  input  logic                   id_load_i,
  input  logic                   id_long_i,
  input  logic [NUM_SRC*AW-1:0]  ex_src_i,
  input  logic                   ex_mem_we_i,
  input  logic                   mem_wb_we_i,
  input  logic [AW-1:0]          ex_mem_rd_i,
  input  logic [AW-1:0]          mem_wb_rd_i,
  input  logic                   long_done_i,
  input  logic [AW-1:0]          long_rd_i,
  output logic                   stall_o,
  output logic [2*NUM_SRC-1:0]   fwd_sel_o,
  output logic                   busy_o,
  output logic [15:0]            stall_cnt_o
);

  localparam int NREG = 2 ** AW;

  logic [NREG-1:0] pending_q, pending_d;
  logic            ld_q, ld_d;
  logic [AW-1:0]   ld_rd_q, ld_rd_d;
  logic [2:0]      out_q, out_d;
  logic [15:0]     stall_cnt_q, stall_cnt_d;

  logic [NUM_SRC-1:0]   raw_hit;
  logic [NUM_SRC-1:0]   lu_hit;
  logic [2*NUM_SRC-1:0] fwd_sel;
  logic                 waw_hit;
  logic                 struct_hit;
  logic                 stall;
  logic                 issue;
  logic                 long_issue;
  logic                 long_set;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [AW-1:0] id_src;
      logic [AW-1:0] ex_src;
      logic          src_live;

      assign id_src   = id_src_i[gi*AW +: AW];
      assign ex_src   = ex_src_i[gi*AW +: AW];
      // Register 0 is hardwired, so it can never carry a dependency.
      assign src_live = id_src_use_i[gi] && (id_src != '0);

      assign raw_hit[gi] = src_live && pending_q[id_src];
      assign lu_hit[gi]  = src_live && ld_q && (id_src == ld_rd_q);

      assign fwd_sel[2*gi +: 2] =
        (ex_mem_we_i && (ex_mem_rd_i != '0) && (ex_mem_rd_i == ex_src)) ? 2'b10 :
        (mem_wb_we_i && (mem_wb_rd_i != '0) && (mem_wb_rd_i == ex_src)) ? 2'b01 :
                                                                          2'b00;
    end
  endgenerate

  assign waw_hit    = id_we_i && (id_rd_i != '0) && pending_q[id_rd_i];
  assign struct_hit = id_long_i && (out_q == 3'(MAX_OUT));
  assign stall      = !rst_i && id_valid_i &&
                      ((|raw_hit) || (|lu_hit) || waw_hit || struct_hit);
  assign issue      = id_valid_i && !stall;
  assign long_issue = issue && id_long_i;
  assign long_set   = long_issue && id_we_i && (id_rd_i != '0);

  always_comb begin
    pending_d = pending_q;
    // Clear first so a same-cycle reissue to the same register keeps it pending.
    if (long_done_i) pending_d[long_rd_i] = 1'b0;
    if (long_set)    pending_d[id_rd_i]   = 1'b1;
    pending_d[0] = 1'b0;

    out_d = out_q;
    if (long_issue && !long_done_i)
      out_d = out_q + 3'd1;
    else if (!long_issue && long_done_i && (out_q != 3'd0))
      out_d = out_q - 3'd1;

    ld_d    = issue && id_load_i && id_we_i && (id_rd_i != '0);
    ld_rd_d = ld_d ? id_rd_i : ld_rd_q;

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q   <= '0;
      ld_q        <= 1'b0;
      ld_rd_q     <= '0;
      out_q       <= 3'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      pending_q   <= pending_d;
      ld_q        <= ld_d;
      ld_rd_q     <= ld_rd_d;
      out_q       <= out_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_o     = stall;
  assign fwd_sel_o   = rst_i ? '0 : fwd_sel;
  assign busy_o      = (out_q != 3'd0);
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter AW, default 5, meaning register address width.
REQ-002 SHALL have parameter NUM_SRC, default 2, meaning number of source operands per instruction.
REQ-003 SHALL have parameter MAX_OUT, default 3, meaning maximum outstanding long-latency writes (1..7).
REQ-004 SHALL have port clk_i  in  1  clock; one clock; all state updates on rising edge.
REQ-005 SHALL have port rst_i  in  1  reset; synchronous, active-high.
REQ-006 SHALL have port id_valid_i  in  1  ID-stage instruction valid.
REQ-007 SHALL have port id_src_i  in  NUM_SRC*AW  ID source register addresses; operand k at bits [k*AW +: AW].
REQ-008 SHALL have port id_src_use_i  in  NUM_SRC  per-operand "source actually read".
REQ-009 SHALL have port id_rd_i  in  AW  ID destination register.
REQ-010 SHALL have port id_we_i  in  1  ID instruction writes id_rd_i.
REQ-011 SHALL have port id_load_i  in  1  ID instruction is a load.
REQ-012 SHALL have port id_long_i  in  1  ID instruction is a long-latency (mul/div) op.
REQ-013 SHALL have port ex_src_i  in  NUM_SRC*AW  ID/EX source registers for forwarding.
REQ-014 SHALL have ports ex_mem_we_i/mem_wb_we_i  in  1 each  stage RegWrite.
REQ-015 SHALL have ports ex_mem_rd_i/mem_wb_rd_i  in  AW each  stage destination.
REQ-016 SHALL have ports long_done_i  in  1 and long_rd_i  in  AW  long unit writeback event and register.
REQ-017 SHALL have port stall_o  out  1  hold PC and IF/ID, insert bubble into ID/EX.
REQ-018 SHALL have port fwd_sel_o  out  2*NUM_SRC  per-operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB.
REQ-019 SHALL have ports busy_o  out  1 (outstanding count nonzero) and stall_cnt_o  out  16 (stall-cycle counter).

Function
REQ-020 SHALL hold state: pending bitmap [2**AW], load flag ld_q with ld_rd_q, outstanding counter out_q (3 bits), stall_cnt_q.
REQ-021 SHALL define "issue" as id_valid_i && !stall_o in the current cycle.
REQ-022 SHALL, per operand k, output 10 if ex_mem_we_i, ex_mem_rd_i!=0 and ex_mem_rd_i==src k; else 01 on same test against MEM/WB; else 00 (EX/MEM has priority).
REQ-023 SHALL compute fwd_sel_o and stall_o combinationally from inputs and registered state (zero latency).
REQ-024 SHALL assert stall_o when id_valid_i and any used operand (id_src_use_i[k], addr!=0) has its pending bit set (RAW on long op).
REQ-025 SHALL assert stall_o when id_valid_i, ld_q=1, and any used nonzero operand equals ld_rd_q (load-use, exactly one bubble).
REQ-026 SHALL assert stall_o when id_valid_i, id_we_i, id_rd_i!=0 and pending[id_rd_i]=1 (WAW).
REQ-027 SHALL assert stall_o when id_valid_i, id_long_i and out_q==MAX_OUT (structural).
REQ-028 SHALL set ld_q<=1, ld_rd_q<=id_rd_i on issue with id_load_i, id_we_i, id_rd_i!=0; otherwise ld_q<=0 next cycle.
REQ-029 SHALL set pending[id_rd_i] on issue with id_long_i, id_we_i, id_rd_i!=0; visible to stall logic the following cycle.
REQ-030 SHALL clear pending[long_rd_i] on long_done_i; on simultaneous set and clear of the same register, set SHALL win.
REQ-031 SHALL increment out_q on long issue, decrement on long_done_i, hold when both; done with out_q==0 SHALL leave out_q at 0.
REQ-032 SHALL never set pending bit 0 nor stall on register 0.
REQ-033 SHALL increment stall_cnt_q each cycle stall_o=1, saturating at 16'hFFFF.
REQ-034 SHALL keep long_done_i processing active during stall cycles.

Reset
REQ-035 SHALL, while rst_i=1 at a clock edge, clear pending, ld_q, ld_rd_q, out_q, stall_cnt_q to 0.
REQ-036 SHALL force stall_o=0 and fwd_sel_o=0 while rst_i=1; busy_o=0 and stall_cnt_o=0 the cycle after reset.
REQ-037 SHALL discard a long_done_i or issue coinciding with rst_i=1.

Verification
REQ-038 SHALL cover: ex_mem rd=3 we=1, mem_wb rd=3 we=1, ex_src k0=3 -> fwd_sel_o[1:0]=10; rd=0 both -> 00.
REQ-039 SHALL cover: issue load rd=5, next cycle id_src0=5 used -> stall_o=1 one cycle, then 0; stall_cnt_o=1.
REQ-040 SHALL cover: issue long rd=7, then id_src1=7 used -> stall until long_done_i rd=7, stall_o=0 same cycle as clear is registered +1.
REQ-041 SHALL cover: MAX_OUT=3 long issues to rd=1,2,3, fourth long -> stall_o=1, busy_o=1; long_done_i rd=1 -> next cycle issue proceeds.
REQ-042 SHALL cover: long issue rd=9 and long_done_i rd=9 same cycle -> pending[9]=1, out_q unchanged.
REQ-043 SHALL cover: rst_i asserted with pending[4]=1, out_q=2 -> next cycle busy_o=0, src=4 no stall.
